// File: rtl/ledfader.sv
// LED fader: each channel's brightness ramps toward its i_led target at a programmable rate
// and is driven out as PWM. Define LEDFADER_GAMMA_EN to apply a square-law duty curve.
module ledfader #(
    parameter int          NLEDS        = 8,
    parameter int          PWMBITS      = 8,
    parameter logic [15:0] DEFAULT_RATE = 16'd1023
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NLEDS-1:0] i_led,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_ack,
    output logic             o_wb_stall,
    output logic [31:0]      o_wb_data,
    output logic [NLEDS-1:0] o_pin
);
    localparam logic [PWMBITS-1:0] LVL_MAX = '1;
    localparam logic [PWMBITS-1:0] LVL_ONE = PWMBITS'(1);

    logic [PWMBITS-1:0] pwm_ctr_q;
    logic [15:0]        rate_q, rate_d;
    logic [15:0]        rate_ctr_q, rate_ctr_d;
    logic               bypass_q, bypass_d;
    logic               ack_q;
    logic [PWMBITS-1:0] level_q [NLEDS];
    logic [PWMBITS-1:0] level_d [NLEDS];
    logic [NLEDS-1:0]   pin_q, pin_d;
    logic               wr;
    logic               tick;
    logic               unused_bits;

    assign unused_bits = ^{i_wb_cyc, i_wb_data[31:17]};

    function automatic logic [PWMBITS-1:0] duty(input logic [PWMBITS-1:0] x);
`ifdef LEDFADER_GAMMA_EN
        logic [2*PWMBITS-1:0] sq;
        sq = {{PWMBITS{1'b0}}, x} * {{PWMBITS{1'b0}}, x};
        return sq[2*PWMBITS-1:PWMBITS];
`else
        return x;
`endif
    endfunction

    // A write reloads the rate timer and suppresses that cycle's tick.
    always_comb begin
        wr       = i_wb_stb & i_wb_we;
        tick     = !wr && (rate_ctr_q == 16'd0);
        rate_d   = wr ? i_wb_data[15:0] : rate_q;
        bypass_d = wr ? i_wb_data[16] : bypass_q;
        if (wr)
            rate_ctr_d = i_wb_data[15:0];
        else if (rate_ctr_q == 16'd0)
            rate_ctr_d = rate_q;
        else
            rate_ctr_d = rate_ctr_q - 16'd1;
    end

    always_comb begin
        pin_d = '0;
        for (int k = 0; k < NLEDS; k++) begin
            level_d[k] = level_q[k];
            if (bypass_q)
                level_d[k] = i_led[k] ? LVL_MAX : '0;
            else if (tick) begin
                if (i_led[k] && (level_q[k] != LVL_MAX))
                    level_d[k] = level_q[k] + LVL_ONE;
                else if (!i_led[k] && (level_q[k] != '0))
                    level_d[k] = level_q[k] - LVL_ONE;
            end
            // Full level forces the pin on; the compare alone would miss one PWM slot.
            pin_d[k] = (level_q[k] == LVL_MAX) | (duty(level_q[k]) > pwm_ctr_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_ctr_q  <= '0;
            rate_q     <= DEFAULT_RATE;
            rate_ctr_q <= DEFAULT_RATE;
            bypass_q   <= 1'b0;
            ack_q      <= 1'b0;
            pin_q      <= '0;
            for (int k = 0; k < NLEDS; k++)
                level_q[k] <= '0;
        end else begin
            pwm_ctr_q  <= pwm_ctr_q + LVL_ONE;
            rate_q     <= rate_d;
            rate_ctr_q <= rate_ctr_d;
            bypass_q   <= bypass_d;
            ack_q      <= i_wb_stb;
            pin_q      <= pin_d;
            for (int k = 0; k < NLEDS; k++)
                level_q[k] <= level_d[k];
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = {15'h0, bypass_q, rate_q};
    assign o_pin      = pin_q;

endmodule

// File: tb/tb_ledfader.sv
// Bench for ledfader: Wishbone readback scored through a queue popped on ack,
// PWM behaviour checked with directed sequences.
`timescale 1ns/1ps
module tb_ledfader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  led = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic        stall;
    logic [31:0] rdata;
    logic [7:0]  pin;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_reg = 32'h0000_03FF;
    logic [31:0] mon_exp;
    logic        stb_seen;

    ledfader dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_led     (led),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_data (wdata),
        .o_wb_ack  (ack),
        .o_wb_stall(stall),
        .o_wb_data (rdata),
        .o_pin     (pin)
    );

    always #5 clk = ~clk;

    // Expected ack: strobe seen at the previous edge, cleared by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) stb_seen <= 1'b0;
        else     stb_seen <= stb;
    end

    always @(negedge clk) begin
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL wb_stall: got %b want 0", stall);
        end
        checks++;
        if (ack !== stb_seen) begin
            errors++;
            $display("FAIL wb_ack_timing: got %b want %b", ack, stb_seen);
        end
        if (ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_ack_unexpected: got ack with data %h, want no ack", rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rdata !== mon_exp) begin
                    errors++;
                    $display("FAIL wb_readback: got %h want %h", rdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] d);
        @(posedge clk); #1;
        stb = 1'b1; we = 1'b1; wdata = d;
        model_reg = {15'h0, d[16], d[15:0]};
        exp_q.push_back(model_reg);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read();
        @(posedge clk); #1;
        stb = 1'b1; we = 1'b0;
        exp_q.push_back(model_reg);
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; stb = 1'b0; we = 1'b0; led = '0;
        model_reg = 32'h0000_03FF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_pin0(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (pin[0]) c++;
        end
    endtask

    initial begin
        int bad;
        int cnt;
        int exp_duty;
        logic found;

        // Reset state, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset_pin", {24'h0, pin}, 32'h0);
        check("reset_readback", rdata, 32'h0000_03FF);
        check("reset_ack", {31'h0, ack}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_pin", {24'h0, pin}, 32'h0);

        // Register access, including upper bits being discarded
        wb_write(32'h0000_0005);
        wb_read();
        wb_write(32'hFFFF_1234);
        wb_read();

        // Bypass
        do_reset();
        led = 8'hA5;
        wb_write(32'h0001_0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bypass_a5", {24'h0, pin}, 32'h0000_00A5);
        wb_read();
        @(posedge clk); #1;
        led = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bypass_5a", {24'h0, pin}, 32'h0000_005A);

        // Fade up at R=0: full level after 255 ticks, pin then stuck on
        do_reset();
        led = 8'h01;
        wb_write(32'h0000_0000);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (pin[7:1] != 7'h0) bad++;
        end
        check("fade_up_others_off", bad, 0);
        bad = 0;
        repeat (256) begin
            @(negedge clk);
            if (pin != 8'h01) bad++;
        end
        check("fade_up_full_on", bad, 0);

        // Fixed duty: 64 ticks then freeze with R=FFFF
        do_reset();
        led = 8'h01;
        wb_write(32'h0000_0000);
        repeat (63) @(posedge clk);
        wb_write(32'h0000_FFFF);
        repeat (4) @(posedge clk);
`ifdef LEDFADER_GAMMA_EN
        exp_duty = 16;
`else
        exp_duty = 64;
`endif
        count_pin0(256, cnt);
        check("fixed_duty_win0", cnt, exp_duty);
        count_pin0(256, cnt);
        check("fixed_duty_win1", cnt, exp_duty);

        // Floor saturation: decrementing at R=0 from level 0 must not wrap
        do_reset();
        led = 8'h00;
        wb_write(32'h0000_0000);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (pin != 8'h00) bad++;
        end
        check("floor_no_wrap", bad, 0);

        // Reset mid-fade at level 100, plus a write dropped during reset
        do_reset();
        led = 8'h01;
        wb_write(32'h0000_0000);
        repeat (99) @(posedge clk);
        wb_write(32'h0000_FFFF);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (pin[0]) found = 1'b1;
        end
        check("midfade_pin_seen", {31'h0, found}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midfade_async_pin", {24'h0, pin}, 32'h0);
        check("midfade_async_readback", rdata, 32'h0000_03FF);
        stb = 1'b1; we = 1'b1; wdata = 32'h0001_1234;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        model_reg = 32'h0000_03FF;
        @(negedge clk);
        rst = 1'b0;
        wb_read();
        repeat (5) @(negedge clk);
        check("midfade_post_release_pin", {24'h0, pin}, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
